// File: rtl/slc3_mem_bridge.sv
// SLC-3 memory/IO bridge: req/ack handshake to SRAM with
// programmable wait states, plus a memory-mapped switch/hex port.
module slc3_mem_bridge #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                WAIT_STATES = 1,
  parameter int                NUM_HEX     = 4,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFFFF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic                 cpu_ack,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic                 busy,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  output logic                 sram_oe,
  output logic                 sram_we,
  input  logic [DATA_W-1:0]    sw,
  output logic [NUM_HEX*4-1:0] hex_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_we_lat;
  logic                  r_oe;
  logic                  r_swe;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [NUM_HEX*4-1:0]  r_hex;
  logic                  w_is_io;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_ack;

  assign w_is_io  = (cpu_addr == IO_ADDR);
  assign w_accept = (r_state == ST_IDLE) && cpu_req;
  assign w_last   = (r_cnt == 4'd0);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and ack decode
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cpu_req)
          w_state_nxt = w_is_io ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_ack       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch request, count wait states, drive SRAM strobes, capture data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_we_lat <= 1'b0;
      r_oe     <= 1'b0;
      r_swe    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_hex    <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= cpu_addr;
        r_wdata  <= cpu_wdata;
        r_we_lat <= cpu_we;
        if (w_is_io) begin
          if (cpu_we) r_hex   <= cpu_wdata[NUM_HEX*4-1:0];
          else        r_rdata <= sw;
        end else begin
          r_cnt <= LP_WS;
          r_oe  <= ~cpu_we;
          r_swe <= cpu_we;
        end
      end else if (r_state == ST_ACCESS) begin
        if (w_last) begin
          if (!r_we_lat) r_rdata <= sram_rdata;
          r_oe  <= 1'b0;
          r_swe <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign cpu_ack    = w_ack;
  assign cpu_rdata  = r_rdata;
  assign busy       = (r_state != ST_IDLE);
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_oe    = r_oe;
  assign sram_we    = r_swe;
  assign hex_out    = r_hex;

endmodule
